// File: rtl/datapath_if.sv
// Purpose: control/data bundle between the CPU controller and the execution datapath.
// Latency: none, wiring only.
// Backpressure: none; the controller drives one set of selects and enables per cycle.
interface datapath_if;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic [15:0] mdata;
    logic [7:0]  PC;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic [2:0]  Z_out;
    logic [15:0] datapath_out;

    // Controller side: drives every select/enable and observes the result.
    modport master (
        output readnum, writenum, write, vsel, loada, loadb, shift, asel, bsel,
        output ALUop, loadc, loads, mdata, PC, sximm5, sximm8,
        input  Z_out, datapath_out
    );

    // Datapath side.
    modport slave (
        input  readnum, writenum, write, vsel, loada, loadb, shift, asel, bsel,
        input  ALUop, loadc, loads, mdata, PC, sximm5, sximm8,
        output Z_out, datapath_out
    );
endinterface

// File: rtl/datapath.sv
// Purpose: 16-bit RISC execution datapath (8x16 regfile, A/B, shifter, ALU, C, status).
// Latency: regfile read is combinational; each register stage (A/B, C/status, write-back) is one edge.
// Backpressure: none; state moves only on the enables the controller asserts each cycle.
module datapath (
    input  logic        clk,
    input  logic        reset,
    datapath_if.slave   bus
);
    logic [15:0] regs [0:7];
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [15:0] c_reg;
    logic [2:0]  status;

    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [15:0] b_shifted;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [15:0] alu_out;
    logic        ovf;
    logic [2:0]  flags;

    // Write-back source select; vsel=00 returns the C value held before the edge.
    always_comb begin
        case (bus.vsel)
            2'b00:   data_in = c_reg;
            2'b01:   data_in = {8'b0, bus.PC};
            2'b10:   data_in = bus.sximm8;
            default: data_in = bus.mdata;
        endcase
    end

    assign data_out = regs[bus.readnum];

    // Register file write; a same-edge read of the target register sees the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 16'h0000;
            end
        end else if (bus.write) begin
            regs[bus.writenum] <= data_in;
        end
    end

    // Operand registers, loaded independently from the regfile read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg <= 16'h0000;
            b_reg <= 16'h0000;
        end else begin
            if (bus.loada) a_reg <= data_out;
            if (bus.loadb) b_reg <= data_out;
        end
    end

    // Shifter on the B path: pass, shift left, logical right, arithmetic right.
    always_comb begin
        case (bus.shift)
            2'b00:   b_shifted = b_reg;
            2'b01:   b_shifted = {b_reg[14:0], 1'b0};
            2'b10:   b_shifted = {1'b0, b_reg[15:1]};
            default: b_shifted = {b_reg[15], b_reg[15:1]};
        endcase
    end

    assign ain = bus.asel ? 16'h0000 : a_reg;
    assign bin = bus.bsel ? bus.sximm5 : b_shifted;

    // ALU and overflow; V only means something for add/sub.
    always_comb begin
        alu_out = 16'h0000;
        ovf     = 1'b0;
        case (bus.ALUop)
            2'b00: begin
                alu_out = ain + bin;
                ovf     = (ain[15] == bin[15]) & (alu_out[15] != ain[15]);
            end
            2'b01: begin
                alu_out = ain - bin;
                ovf     = (ain[15] != bin[15]) & (alu_out[15] != ain[15]);
            end
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
    end

    assign flags = {ovf, alu_out[15], (alu_out == 16'h0000)};

    // Result and status registers, independently enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_reg  <= 16'h0000;
            status <= 3'b000;
        end else begin
            if (bus.loadc) c_reg  <= alu_out;
            if (bus.loads) status <= flags;
        end
    end

    assign bus.datapath_out = c_reg;
    assign bus.Z_out        = status;
endmodule

// File: tb/tb_datapath.sv
// Purpose: directed + random bench for datapath against a behavioural model.
// Latency: each step drives inputs after an edge and checks one edge later.
// Backpressure: n/a.
module tb_datapath;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    datapath_if d();
    datapath dut (.clk(clk), .reset(reset), .bus(d.slave));

    always #5 clk = ~clk;

    // Behavioural state of the datapath.
    logic [15:0] m_r [8];
    logic [15:0] m_a, m_b, m_c;
    logic [2:0]  m_s;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
        m_a = 16'h0; m_b = 16'h0; m_c = 16'h0; m_s = 3'b0;
    endtask

    // Two's-complement arithmetic done on integers; overflow is "result leaves 16-bit signed range".
    function automatic void model_alu(input logic [15:0] x, input logic [15:0] y,
                                      input logic [1:0] op,
                                      output logic [15:0] r, output logic v);
        int sx, sy, s;
        sx = int'($signed(x));
        sy = int'($signed(y));
        s  = 0;
        r  = 16'h0;
        v  = 1'b0;
        case (op)
            2'd0: begin s = sx + sy; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            2'd1: begin s = sx - sy; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            2'd2: r = x & y;
            default: r = ~y;
        endcase
    endfunction

    // One clock: predict from pre-edge state and inputs, then compare outputs.
    task automatic step();
        logic [15:0] rd, din, sh, ain, bin, res;
        logic v;
        rd = m_r[d.readnum];
        case (d.vsel)
            2'd0: din = m_c;
            2'd1: din = {8'h00, d.PC};
            2'd2: din = d.sximm8;
            default: din = d.mdata;
        endcase
        case (d.shift)
            2'd0: sh = m_b;
            2'd1: sh = m_b << 1;
            2'd2: sh = m_b >> 1;
            default: sh = 16'($signed(m_b) >>> 1);
        endcase
        ain = d.asel ? 16'h0 : m_a;
        bin = d.bsel ? d.sximm5 : sh;
        model_alu(ain, bin, d.ALUop, res, v);
        @(posedge clk);
        #1;
        if (d.write) m_r[d.writenum] = din;
        if (d.loada) m_a = rd;
        if (d.loadb) m_b = rd;
        if (d.loadc) m_c = res;
        if (d.loads) m_s = {v, ($signed(res) < 0), (res == 16'h0)};
        chk("model_c", d.datapath_out, m_c);
        chk("model_status", {13'h0, d.Z_out}, {13'h0, m_s});
    endtask

    task automatic idle();
        d.write = 0; d.loada = 0; d.loadb = 0; d.loadc = 0; d.loads = 0;
        d.vsel = 0; d.shift = 0; d.asel = 0; d.bsel = 0; d.ALUop = 0;
    endtask

    task automatic wr(input logic [2:0] r, input logic [1:0] src, input logic [15:0] val);
        idle();
        d.vsel = src; d.writenum = r; d.write = 1;
        d.sximm8 = val; d.mdata = val; d.PC = val[7:0];
        step();
    endtask

    task automatic ld_a(input logic [2:0] r);
        idle(); d.readnum = r; d.loada = 1; step();
    endtask

    task automatic ld_b(input logic [2:0] r);
        idle(); d.readnum = r; d.loadb = 1; step();
    endtask

    task automatic op(input logic as, input logic bs, input logic [1:0] sh,
                      input logic [1:0] al, input logic ls);
        idle();
        d.asel = as; d.bsel = bs; d.shift = sh; d.ALUop = al; d.loadc = 1; d.loads = ls;
        step();
    endtask

    task automatic wb_c(input logic [2:0] r);
        idle(); d.vsel = 0; d.writenum = r; d.write = 1; step();
    endtask

    // Read a register out through B -> MOV -> C (clobbers B and C).
    task automatic read_reg(input logic [2:0] r, input logic [15:0] exp, input string tag);
        ld_b(r);
        op(1, 0, 2'd0, 2'd0, 0);
        chk(tag, d.datapath_out, exp);
    endtask

    initial begin
        d.readnum = 0; d.writenum = 0; d.mdata = 0; d.PC = 0; d.sximm5 = 0; d.sximm8 = 0;
        idle();
        reset = 1;
        model_clear();
        #1;
        chk("reset_c", d.datapath_out, 16'h0);
        chk("reset_status", {13'h0, d.Z_out}, 16'h0);
        @(posedge clk); #1;
        reset = 0;

        // ADD with shift: 18 + (76<<1) = 170
        wr(3'd0, 2'd2, 16'd18);
        wr(3'd1, 2'd2, 16'd76);
        ld_a(0);
        ld_b(1);
        op(0, 0, 2'd1, 2'd0, 1);
        chk("add_c", d.datapath_out, 16'd170);
        chk("add_status", {13'h0, d.Z_out}, 16'h0);
        wb_c(2);

        // SUB 170-32 = 138 without status load, then R3-R3 = 0 with status
        wr(3'd3, 2'd2, 16'd32);
        ld_a(2);
        ld_b(3);
        op(0, 0, 2'd0, 2'd1, 0);
        chk("sub_c", d.datapath_out, 16'd138);
        chk("sub_status_held", {13'h0, d.Z_out}, 16'h0);
        wb_c(3);
        ld_a(3);
        ld_b(3);
        op(0, 0, 2'd0, 2'd1, 1);
        chk("subz_c", d.datapath_out, 16'h0);
        chk("subz_status", {13'h0, d.Z_out}, 16'h1);

        read_reg(2, 16'd170, "r2_wb");
        read_reg(3, 16'd138, "r3_wb");

        // MOV with LSR and ASR
        ld_b(0);
        op(1, 0, 2'd2, 2'd0, 0);
        chk("lsr_c", d.datapath_out, 16'd9);
        wr(3'd4, 2'd3, 16'h8002);
        ld_b(4);
        op(1, 0, 2'd3, 2'd0, 0);
        chk("asr_c", d.datapath_out, 16'hC001);

        // AND 138 & 76 = 8, NOT of immediate 9
        ld_a(3);
        ld_b(1);
        op(0, 0, 2'd0, 2'd2, 0);
        chk("and_c", d.datapath_out, 16'd8);
        d.sximm5 = 16'h0009;
        op(0, 1, 2'd0, 2'd3, 1);
        chk("not_c", d.datapath_out, 16'hFFF6);
        chk("not_status", {13'h0, d.Z_out}, 16'h2);

        // Signed overflow 0x7FFF + 1
        wr(3'd5, 2'd2, 16'h7FFF);
        wr(3'd6, 2'd2, 16'h0001);
        ld_a(5);
        ld_b(6);
        op(0, 0, 2'd0, 2'd0, 1);
        chk("ovf_c", d.datapath_out, 16'h8000);
        chk("ovf_status", {13'h0, d.Z_out}, 16'h6);

        // Other write-back sources
        wr(3'd7, 2'd1, 16'h00A5);
        read_reg(7, 16'h00A5, "wb_pc");
        wr(3'd4, 2'd3, 16'h1234);
        read_reg(4, 16'h1234, "wb_mdata");

        // Same-edge read/write of R0: A must capture the old 18
        idle();
        d.readnum = 0; d.loada = 1;
        d.writenum = 0; d.write = 1; d.vsel = 2; d.sximm8 = 16'h5555;
        step();
        d.sximm5 = 16'h0;
        op(0, 1, 2'd0, 2'd0, 0);
        chk("rw_same_edge", d.datapath_out, 16'd18);
        read_reg(0, 16'h5555, "rw_new_value");

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            d.readnum  = 3'($urandom_range(0, 7));
            d.writenum = 3'($urandom_range(0, 7));
            d.write    = 1'($urandom);
            d.vsel     = 2'($urandom);
            d.loada    = 1'($urandom);
            d.loadb    = 1'($urandom);
            d.shift    = 2'($urandom);
            d.asel     = 1'($urandom);
            d.bsel     = 1'($urandom);
            d.ALUop    = 2'($urandom);
            d.loadc    = 1'($urandom);
            d.loads    = 1'($urandom);
            d.mdata    = 16'($urandom);
            d.PC       = 8'($urandom);
            d.sximm5   = 16'($signed(5'($urandom)));
            d.sximm8   = (n % 7 == 0) ? 16'h7FFF : 16'($signed(8'($urandom)));
            step();
        end

        // Async reset mid-cycle with C/status nonzero and enables asserted
        d.sximm5 = 16'h0;
        op(1, 1, 2'd0, 2'd3, 1);
        chk("pre_reset_c", d.datapath_out, 16'hFFFF);
        d.write = 1; d.vsel = 2; d.sximm8 = 16'h1111; d.loada = 1; d.loadb = 1;
        #3;
        reset = 1;
        #1;
        chk("async_reset_c", d.datapath_out, 16'h0);
        chk("async_reset_status", {13'h0, d.Z_out}, 16'h0);
        @(posedge clk); #1;
        chk("reset_override_c", d.datapath_out, 16'h0);
        chk("reset_override_status", {13'h0, d.Z_out}, 16'h0);
        reset = 0;
        model_clear();
        read_reg(0, 16'h0, "reset_r0");
        read_reg(5, 16'h0, "reset_r5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
